// File: rtl/serv_seq_pkg.sv
// Shared types and trap cause codes for the serv_seq instruction sequencer.
package serv_seq_pkg;

    typedef enum logic [2:0] {
        FETCH, RREQ, IDLE, INIT, MEM, SHIFT, RUN, TRAP
    } state_t;

    localparam logic [3:0] MCAUSE_INSN_MISALIGN  = 4'd0;
    localparam logic [3:0] MCAUSE_EBREAK         = 4'd3;
    localparam logic [3:0] MCAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] MCAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] MCAUSE_TIMER_IRQ      = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL          = 4'd11;

    function automatic logic [3:0] env_cause(input logic ebreak);
        return ebreak ? MCAUSE_EBREAK : MCAUSE_ECALL;
    endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// Beat counter: CW-bit counter that wraps after 32/W beats, exposing the LSB bit index.
module serv_seq_cnt #(
    parameter int W  = 1,
    parameter int CW = $clog2(32 / W)
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    output logic [4:0] cnt,
    output logic       cnt_done
);
    localparam int SH = $clog2(W);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign cnt_done = en & (&count_reg);

    // Each beat covers W bits, so the bit index is the beat number shifted up.
    generate
        if (SH == 0) begin : g_narrow
            assign cnt = count_reg;
        end else begin : g_wide
            assign cnt = {count_reg, {SH{1'b0}}};
        end
    endgenerate

endmodule

// File: rtl/serv_seq.sv
// Two-phase instruction sequencer for the W-bit serial core.
// Define SERV_SEQ_IRQ_EN to include the interrupt latch and the TRAP-on-irq path.
module serv_seq
    import serv_seq_pkg::*;
#(
    parameter int W              = 1,
    parameter int CW             = $clog2(32 / W),
    parameter bit RESET_PC_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       i_rst,
    output logic       o_ibus_cyc,
    input  logic       i_ibus_ack,
    output logic       o_rf_rreq,
    input  logic       i_rf_ready,
    input  logic       i_two_stage,
    input  logic       i_mem_op,
    input  logic       i_mem_we,
    input  logic       i_shift_op,
    input  logic       i_branch_op,
    input  logic       i_e_op,
    input  logic       i_ebreak,
    input  logic       i_take_branch,
    input  logic       i_ctrl_misalign,
    input  logic       i_mem_misalign,
    input  logic       i_sh_done,
    input  logic       i_new_irq,
    output logic       o_dbus_cyc,
    input  logic       i_dbus_ack,
    output logic       o_init,
    output logic       o_run,
    output logic       o_cnt_en,
    output logic       o_cnt_done,
    output logic       o_pc_en,
    output logic       o_trap,
    output logic [4:0] o_cnt,
    output logic [3:0] o_mcause,
    output logic       o_mcause_irq
);
    state_t     state_reg, state_next;
    logic [3:0] mcause_reg, trap_cause;
    logic       mcause_irq_reg, trap_irq, trap_entry;
    logic       irq_pending;
    logic       cnt_done;

    serv_seq_cnt #(.W(W), .CW(CW)) u_cnt (
        .clk      (clk),
        .clr      (i_rst),
        .en       (o_cnt_en),
        .cnt      (o_cnt),
        .cnt_done (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg <= RESET_PC_FETCH ? FETCH : IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        trap_entry = 1'b0;
        trap_cause = mcause_reg;
        trap_irq   = 1'b0;
        case (state_reg)
            FETCH: if (i_ibus_ack) state_next = RREQ;
            RREQ:  state_next = IDLE;
            IDLE: begin
                if (i_rf_ready) begin
                    if (irq_pending) begin
                        state_next = TRAP;
                        trap_entry = 1'b1;
                        trap_cause = MCAUSE_TIMER_IRQ;
                        trap_irq   = 1'b1;
                    end else if (i_e_op) begin
                        state_next = TRAP;
                        trap_entry = 1'b1;
                        trap_cause = env_cause(i_ebreak);
                    end else begin
                        state_next = i_two_stage ? INIT : RUN;
                    end
                end
            end
            INIT: begin
                if (cnt_done) begin
                    if (i_mem_op && i_mem_misalign) begin
                        state_next = TRAP;
                        trap_entry = 1'b1;
                        trap_cause = i_mem_we ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN;
                    end else if (i_mem_op) begin
                        state_next = MEM;
                    end else if (i_shift_op) begin
                        state_next = SHIFT;
                    end else if (i_branch_op && i_take_branch && i_ctrl_misalign) begin
                        state_next = TRAP;
                        trap_entry = 1'b1;
                        trap_cause = MCAUSE_INSN_MISALIGN;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            MEM:   if (i_dbus_ack) state_next = RUN;
            SHIFT: if (i_sh_done) state_next = RUN;
            RUN:   if (cnt_done) state_next = FETCH;
            TRAP:  if (cnt_done) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // Cause is only rewritten on trap entry so CSR logic can read it afterwards.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            mcause_reg     <= '0;
            mcause_irq_reg <= 1'b0;
        end else if (trap_entry) begin
            mcause_reg     <= trap_cause;
            mcause_irq_reg <= trap_irq;
        end
    end

`ifdef SERV_SEQ_IRQ_EN
    logic irq_pending_reg;

    // Held until the next instruction boundary so an irq never splits an instruction.
    always_ff @(posedge clk) begin
        if (i_rst || trap_entry) begin
            irq_pending_reg <= 1'b0;
        end else if (state_reg != TRAP) begin
            irq_pending_reg <= irq_pending_reg | i_new_irq;
        end
    end

    assign irq_pending = irq_pending_reg;
`else
    logic unused_new_irq;
    assign unused_new_irq = i_new_irq;
    assign irq_pending    = 1'b0;
`endif

    assign o_ibus_cyc   = (state_reg == FETCH);
    assign o_rf_rreq    = (state_reg == RREQ);
    assign o_dbus_cyc   = (state_reg == MEM);
    assign o_init       = (state_reg == INIT);
    assign o_trap       = (state_reg == TRAP);
    assign o_run        = (state_reg == RUN) || (state_reg == TRAP);
    assign o_pc_en      = o_run;
    assign o_cnt_en     = o_init || o_run;
    assign o_cnt_done   = cnt_done;
    assign o_mcause     = mcause_reg;
    assign o_mcause_irq = mcause_irq_reg;

endmodule

// File: tb/tb_serv_seq.sv
// Directed bench for serv_seq: three instances (W=1,2,4) share stimulus; each test watches one.
module tb_serv_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ibus_ack = 0, rf_ready = 0, two_stage = 0, mem_op = 0, mem_we = 0;
    logic shift_op = 0, branch_op = 0, e_op = 0, ebreak = 0, take_branch = 0;
    logic ctrl_mis = 0, mem_mis = 0, sh_done = 0, new_irq = 0, dbus_ack = 0;

    logic       ibus_cyc_a[3], rreq_a[3], dbus_cyc_a[3], init_a[3], run_a[3];
    logic       cnt_en_a[3], done_a[3], pc_en_a[3], trap_a[3], mirq_a[3];
    logic [4:0] cnt_a[3];
    logic [3:0] mcause_a[3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            serv_seq #(.W(1 << gi)) dut (
                .clk(clk), .i_rst(rst),
                .o_ibus_cyc(ibus_cyc_a[gi]), .i_ibus_ack(ibus_ack),
                .o_rf_rreq(rreq_a[gi]), .i_rf_ready(rf_ready),
                .i_two_stage(two_stage), .i_mem_op(mem_op), .i_mem_we(mem_we),
                .i_shift_op(shift_op), .i_branch_op(branch_op), .i_e_op(e_op),
                .i_ebreak(ebreak), .i_take_branch(take_branch),
                .i_ctrl_misalign(ctrl_mis), .i_mem_misalign(mem_mis),
                .i_sh_done(sh_done), .i_new_irq(new_irq),
                .o_dbus_cyc(dbus_cyc_a[gi]), .i_dbus_ack(dbus_ack),
                .o_init(init_a[gi]), .o_run(run_a[gi]), .o_cnt_en(cnt_en_a[gi]),
                .o_cnt_done(done_a[gi]), .o_pc_en(pc_en_a[gi]), .o_trap(trap_a[gi]),
                .o_cnt(cnt_a[gi]), .o_mcause(mcause_a[gi]), .o_mcause_irq(mirq_a[gi])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (W=%0d): got=%0h expected=%0h", tag, 1 << sel, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_decode();
        two_stage = 0; mem_op = 0; mem_we = 0; shift_op = 0; branch_op = 0;
        e_op = 0; ebreak = 0; take_branch = 0; ctrl_mis = 0; mem_mis = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // From FETCH: ack, see the one-cycle rreq, land in IDLE.
    task automatic fetch();
        check("fetch_ibus", ibus_cyc_a[sel], 1);
        ibus_ack = 1;
        step();
        ibus_ack = 0;
        check("rreq_pulse", rreq_a[sel], 1);
        check("rreq_ibus_low", ibus_cyc_a[sel], 0);
        step();
        check("rreq_end", rreq_a[sel], 0);
    endtask

    task automatic grant(input int wait_cycles);
        repeat (wait_cycles) begin
            check("idle_no_cnt", cnt_en_a[sel], 0);
            step();
        end
        rf_ready = 1;
        step();
        rf_ready = 0;
    endtask

    task automatic beats(input string tag, input int n, input logic exp_init,
                         input logic exp_trap, input int irq_at);
        int w;
        w = 1 << sel;
        for (int i = 0; i < n; i++) begin
            check({tag, "_init"}, init_a[sel], exp_init);
            check({tag, "_run"}, run_a[sel], !exp_init);
            check({tag, "_trap"}, trap_a[sel], exp_trap);
            check({tag, "_pc_en"}, pc_en_a[sel], !exp_init);
            check({tag, "_cnt"}, cnt_a[sel], (i * w) % 32);
            check({tag, "_done"}, done_a[sel], (i == n - 1));
            check({tag, "_dbus"}, dbus_cyc_a[sel], 0);
            if (i == irq_at) new_irq = 1;
            step();
            new_irq = 0;
        end
    endtask

    initial begin
        // Reset state on the W=1 instance
        sel = 0;
        do_reset();
        check("rst_ibus", ibus_cyc_a[sel], 1);
        check("rst_rreq", rreq_a[sel], 0);
        check("rst_dbus", dbus_cyc_a[sel], 0);
        check("rst_cnt_en", cnt_en_a[sel], 0);
        check("rst_cnt", cnt_a[sel], 0);
        check("rst_mcause", mcause_a[sel], 0);
        check("rst_mirq", mirq_a[sel], 0);

        // W=1 ALU op, grant three cycles after the rreq pulse
        clear_decode();
        fetch();
        grant(2);
        beats("add_w1", 32, 0, 0, -1);
        check("add_w1_refetch", ibus_cyc_a[sel], 1);
        $display("test add W=1 complete");

        // W=4 load, dbus acked on the fifth cycle
        sel = 2;
        do_reset();
        clear_decode();
        two_stage = 1; mem_op = 1;
        fetch();
        grant(0);
        beats("load_init", 8, 1, 0, -1);
        for (int k = 0; k < 5; k++) begin
            check("load_dbus", dbus_cyc_a[sel], 1);
            check("load_no_ibus", ibus_cyc_a[sel], 0);
            check("load_mem_hold", cnt_en_a[sel], 0);
            if (k == 4) dbus_ack = 1;
            step();
            dbus_ack = 0;
        end
        beats("load_run", 8, 0, 0, -1);
        check("load_refetch", ibus_cyc_a[sel], 1);
        $display("test load W=4 complete");

        // W=2 misaligned store traps without touching the data bus
        sel = 1;
        do_reset();
        clear_decode();
        two_stage = 1; mem_op = 1; mem_we = 1; mem_mis = 1;
        fetch();
        grant(0);
        beats("st_init", 16, 1, 0, -1);
        check("st_mcause", mcause_a[sel], 6);
        beats("st_trap", 16, 0, 1, -1);
        check("st_mcause_hold", mcause_a[sel], 6);
        check("st_refetch", ibus_cyc_a[sel], 1);
        $display("test misaligned store W=2 complete");

        // W=4 irq pulsed mid-RUN is deferred to the next grant
        sel = 2;
        do_reset();
        clear_decode();
        fetch();
        grant(0);
        beats("irq_run", 8, 0, 0, 3);
        fetch();
        grant(0);
`ifdef SERV_SEQ_IRQ_EN
        check("irq_mcause", mcause_a[sel], 7);
        check("irq_flag", mirq_a[sel], 1);
        beats("irq_trap", 8, 0, 1, -1);
`else
        check("irq_mcause", mcause_a[sel], 0);
        check("irq_flag", mirq_a[sel], 0);
        beats("irq_ignored", 8, 0, 0, -1);
`endif
        $display("test irq W=4 complete");

        // W=4 ecall, ebreak, then misaligned taken branch, back to back
        do_reset();
        clear_decode();
        e_op = 1;
        fetch();
        grant(0);
        check("ecall_mcause", mcause_a[sel], 11);
        check("ecall_mirq", mirq_a[sel], 0);
        beats("ecall_trap", 8, 0, 1, -1);
        ebreak = 1;
        fetch();
        grant(0);
        check("ebreak_mcause", mcause_a[sel], 3);
        beats("ebreak_trap", 8, 0, 1, -1);
        clear_decode();
        two_stage = 1; branch_op = 1; take_branch = 1; ctrl_mis = 1;
        fetch();
        grant(0);
        beats("br_init", 8, 1, 0, -1);
        check("br_mcause", mcause_a[sel], 0);
        beats("br_trap", 8, 0, 1, -1);
        check("br_refetch", ibus_cyc_a[sel], 1);
        $display("test env/branch traps W=4 complete");

        // W=4 shift waits for the shifter before RUN
        clear_decode();
        two_stage = 1; shift_op = 1;
        fetch();
        grant(0);
        beats("sh_init", 8, 1, 0, -1);
        repeat (3) begin
            check("sh_hold_cnt_en", cnt_en_a[sel], 0);
            check("sh_hold_run", run_a[sel], 0);
            step();
        end
        sh_done = 1;
        step();
        sh_done = 0;
        beats("sh_run", 8, 0, 0, -1);
        $display("test shift W=4 complete");

        // Reset during MEM aborts the data bus cycle
        clear_decode();
        two_stage = 1; mem_op = 1;
        fetch();
        grant(0);
        beats("rm_init", 8, 1, 0, -1);
        check("rm_dbus", dbus_cyc_a[sel], 1);
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        check("rm_dbus_abort", dbus_cyc_a[sel], 0);
        check("rm_ibus", ibus_cyc_a[sel], 1);
        check("rm_cnt", cnt_a[sel], 0);
        check("rm_mcause", mcause_a[sel], 0);
        $display("test reset in MEM W=4 complete");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
